serial_adder_ctrl: RTL and testbench

//  Bit-serial adder controller: time-shares one half-adder pair (a full-adder cell) across WIDTH cycles.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/serial_adder_ctrl_if.sv | 34 +++
 rtl/sa_full_adder_cell.sv | 17 +
 rtl/serial_adder_ctrl.sv | 114 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// The SERIAL_ADDER_OVF_EN macro (see serial_adder_ctrl) adds a signed-overflow output.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } sa_state_e;

   localparam int WIDTH_MAX = 32;

   // Bit counter width: max(1, clog2(w)) so WIDTH=1 still gets a real register
   function automatic int cnt_w(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Start/busy/done handshake and operand/result bus of the serial adder.
// overflow exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             carry_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
`ifdef SERIAL_ADDER_OVF_EN
   logic             overflow;
`endif

   modport master (
      output start, op_a, op_b, carry_in,
      input  busy, done, sum, carry_out
`ifdef SERIAL_ADDER_OVF_EN
      , input overflow
`endif
   );

   modport slave (
      input  start, op_a, op_b, carry_in,
      output busy, done, sum, carry_out
`ifdef SERIAL_ADDER_OVF_EN
      , output overflow
`endif
   );

endinterface

// File: rtl/sa_full_adder_cell.sv
// Shared add cell: two half adders plus an OR form one full adder.
module sa_full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);
   logic hs, hc0, hc1;

   assign hs  = a ^ b;
   assign hc0 = a & b;
   assign s   = hs ^ c;
   assign hc1 = hs & c;
   assign co  = hc0 | hc1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused over WIDTH cycles, LSB first.
// Optional SERIAL_ADDER_OVF_EN adds a registered signed-overflow output.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               CLOCK_50,
   input  logic               RESET,
   serial_adder_ctrl_if.slave bus
);
   localparam int CNT_W = cnt_w(WIDTH);

   sa_state_e        state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q, res_q, res_nxt;
   logic [WIDTH-1:0] sum_q;
   logic             c_q, cout_q;
   logic [CNT_W-1:0] bit_cnt;
   logic             last_bit;
   logic             fa_s, fa_co;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q;
`endif

   sa_full_adder_cell u_fa (
      .a  (a_q[0]),
      .b  (b_q[0]),
      .c  (c_q),
      .s  (fa_s),
      .co (fa_co)
   );

   assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));
   // New sum bit enters at the MSB; form works for WIDTH=1 too
   assign res_nxt  = (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (bus.start) state_nxt = ST_SHIFT;
         ST_SHIFT: if (last_bit)  state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.busy = 1'b0;
      bus.done = 1'b0;
      case (state)
         ST_SHIFT: bus.busy = 1'b1;
         ST_DONE: begin
            bus.busy = 1'b1;
            bus.done = 1'b1;
         end
         default: ;
      endcase
   end

   // Outputs load on the final shift so they are already valid while done is high
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         c_q     <= 1'b0;
         bit_cnt <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  a_q     <= bus.op_a;
                  b_q     <= bus.op_b;
                  c_q     <= bus.carry_in;
                  bit_cnt <= '0;
               end
            end
            ST_SHIFT: begin
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               c_q     <= fa_co;
               res_q   <= res_nxt;
               bit_cnt <= bit_cnt + CNT_W'(1);
               if (last_bit) begin
                  sum_q  <= res_nxt;
                  cout_q <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                  // c_q here is the carry into the MSB
                  ovf_q  <= c_q ^ fa_co;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.sum       = sum_q;
   assign bus.carry_out = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign bus.overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

   logic CLOCK_50 = 1'b0;
   logic RESET    = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
   serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

   serial_adder_ctrl #(.WIDTH(8)) dut8 (.CLOCK_50(CLOCK_50), .RESET(RESET), .bus(bus8));
   serial_adder_ctrl #(.WIDTH(1)) dut1 (.CLOCK_50(CLOCK_50), .RESET(RESET), .bus(bus1));

   initial begin
      bus8.start = 0; bus8.op_a = 0; bus8.op_b = 0; bus8.carry_in = 0;
      bus1.start = 0; bus1.op_a = 0; bus1.op_b = 0; bus1.carry_in = 0;
   end

   task automatic test_reset();
      RESET = 1'b1;
      repeat (2) @(negedge CLOCK_50);
      checks++; if (bus8.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus8.busy); end
      checks++; if (bus8.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus8.done); end
      checks++; if (bus8.sum !== 8'h00) begin failures++; $display("FAIL rst_sum got=%h exp=00", bus8.sum); end
      checks++; if (bus8.carry_out !== 1'b0) begin failures++; $display("FAIL rst_cout got=%b exp=0", bus8.carry_out); end
`ifdef SERIAL_ADDER_OVF_EN
      checks++; if (bus8.overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", bus8.overflow); end
`endif
      checks++; if (bus1.busy !== 1'b0 || bus1.sum !== 1'b0) begin failures++; $display("FAIL rst_w1 busy=%b sum=%b exp=0,0", bus1.busy, bus1.sum); end
      RESET = 1'b0;
      @(negedge CLOCK_50);
   endtask

   // One operation on the 8-bit DUT, assumed idle on entry
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] es, input logic ec, input logic eo, input string nm);
      int n;
      bus8.start = 1; bus8.op_a = a; bus8.op_b = b; bus8.carry_in = cin;
      @(negedge CLOCK_50);
      bus8.start = 0; bus8.op_a = 8'h5A; bus8.op_b = 8'hC3; bus8.carry_in = ~cin;
      n = 1;
      checks++; if (bus8.busy !== 1'b1) begin failures++; $display("FAIL %s_busy got=%b exp=1", nm, bus8.busy); end
      while (bus8.done !== 1'b1 && n < 20) begin @(negedge CLOCK_50); n++; end
      checks++; if (n != 9) begin failures++; $display("FAIL %s_latency got=%0d exp=9", nm, n); end
      checks++; if (bus8.sum !== es) begin failures++; $display("FAIL %s_sum got=%h exp=%h", nm, bus8.sum, es); end
      checks++; if (bus8.carry_out !== ec) begin failures++; $display("FAIL %s_cout got=%b exp=%b", nm, bus8.carry_out, ec); end
`ifdef SERIAL_ADDER_OVF_EN
      checks++; if (bus8.overflow !== eo) begin failures++; $display("FAIL %s_ovf got=%b exp=%b", nm, bus8.overflow, eo); end
`else
      if (eo === 1'bx) $display("note: unexpected x overflow expectation");
`endif
      @(negedge CLOCK_50);
      checks++; if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin failures++; $display("FAIL %s_after done=%b busy=%b exp=0,0", nm, bus8.done, bus8.busy); end
      checks++; if (bus8.sum !== es) begin failures++; $display("FAIL %s_hold got=%h exp=%h", nm, bus8.sum, es); end
   endtask

   task automatic test_basic();
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff_01");
      run_op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, "12_34_c");
   endtask

   task automatic test_overflow();
      run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "7f_01");
      run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "80_80");
      run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "ff_ff_c");
   endtask

   task automatic test_start_while_busy();
      int dones = 0, done_n = 0;
      logic [7:0] s = 8'h00;
      bus8.start = 1; bus8.op_a = 8'h12; bus8.op_b = 8'h34; bus8.carry_in = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge CLOCK_50);
         if (n == 3) begin bus8.start = 1; bus8.op_a = 8'hAA; end
         else        begin bus8.start = 0; bus8.op_a = 8'h12; end
         if (bus8.done === 1'b1) begin dones++; done_n = n; s = bus8.sum; end
      end
      checks++; if (dones != 1) begin failures++; $display("FAIL ign_dones got=%0d exp=1", dones); end
      checks++; if (done_n != 9) begin failures++; $display("FAIL ign_latency got=%0d exp=9", done_n); end
      checks++; if (s !== 8'h46) begin failures++; $display("FAIL ign_sum got=%h exp=46", s); end
   endtask

   task automatic test_abort();
      int dones = 0;
      bus8.start = 1; bus8.op_a = 8'h0F; bus8.op_b = 8'h0F; bus8.carry_in = 0;
      @(negedge CLOCK_50);
      bus8.start = 0;
      repeat (3) @(negedge CLOCK_50);
      RESET = 1'b1;
      #1;
      checks++; if (bus8.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus8.busy); end
      checks++; if (bus8.sum !== 8'h00) begin failures++; $display("FAIL abort_sum got=%h exp=00", bus8.sum); end
      @(negedge CLOCK_50);
      RESET = 1'b0;
      for (int n = 0; n < 12; n++) begin
         @(negedge CLOCK_50);
         if (bus8.done === 1'b1) dones++;
      end
      checks++; if (dones != 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", dones); end
      run_op(8'h0F, 8'h0F, 1'b0, 8'h1E, 1'b0, 1'b0, "after_abort");
   endtask

   task automatic test_back_to_back();
      int n;
      bus8.start = 1; bus8.op_a = 8'h05; bus8.op_b = 8'h03; bus8.carry_in = 1;
      n = 0;
      do begin @(negedge CLOCK_50); n++; end while (bus8.done !== 1'b1 && n < 30);
      checks++; if (bus8.done !== 1'b1 || bus8.sum !== 8'h09) begin failures++; $display("FAIL b2b_first done=%b sum=%h exp=1,09", bus8.done, bus8.sum); end
      for (int r = 0; r < 2; r++) begin
         int idle = 0;
         n = 0;
         do begin
            @(negedge CLOCK_50); n++;
            if (bus8.busy === 1'b0) idle++;
         end while (bus8.done !== 1'b1 && n < 30);
         checks++; if (n != 10) begin failures++; $display("FAIL b2b_period%0d got=%0d exp=10", r, n); end
         checks++; if (idle != 1) begin failures++; $display("FAIL b2b_idle%0d got=%0d exp=1", r, idle); end
         checks++; if (bus8.sum !== 8'h09 || bus8.carry_out !== 1'b0) begin failures++; $display("FAIL b2b_sum%0d got=%h/%b exp=09/0", r, bus8.sum, bus8.carry_out); end
      end
      bus8.start = 0;
      repeat (12) @(negedge CLOCK_50);
   endtask

   task automatic test_width1();
      logic [2:0] vec [2] = '{3'b111, 3'b100};
      logic [1:0] exp [2] = '{2'b11, 2'b01};
      int n;
      for (int i = 0; i < 2; i++) begin
         bus1.start = 1; bus1.op_a = vec[i][2]; bus1.op_b = vec[i][1]; bus1.carry_in = vec[i][0];
         @(negedge CLOCK_50);
         bus1.start = 0;
         n = 1;
         checks++; if (bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin failures++; $display("FAIL w1_shift%0d busy=%b done=%b exp=1,0", i, bus1.busy, bus1.done); end
         while (bus1.done !== 1'b1 && n < 10) begin @(negedge CLOCK_50); n++; end
         checks++; if (n != 2) begin failures++; $display("FAIL w1_latency%0d got=%0d exp=2", i, n); end
         checks++; if ({bus1.carry_out, bus1.sum} !== exp[i]) begin failures++; $display("FAIL w1_result%0d got=%b%b exp=%b", i, bus1.carry_out, bus1.sum, exp[i]); end
         @(negedge CLOCK_50);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_start_while_busy();
      test_abort();
      test_back_to_back();
      test_width1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
